branch_resolve: RTL and testbench

Execute-stage branch/jump resolution unit: the producer of the `PCsrcE` / `PCTargetE` redirect that the fetch stage consumes. It holds the ID/EX control-flow pipeline register and evaluates conditional branches, JAL and JALR from registered operands. It drives the taken flag and target back to fetch, and issues the flush that squashes the wrong-path instruction in the fetch/decode register.

---
 rtl/branch_resolve.sv | 143 ++++++++++++++
 tb/tb_branch_resolve.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch/jump resolution with ID/EX control-flow register
//
// Holds the ID/EX control-flow pipeline register and resolves conditional
// branches, JAL and JALR from the registered operands. A taken instruction
// raises PCsrcE/FlushD for exactly one cycle and drives PCTargetE to fetch.
//
// Optional feature macro: BRANCH_STATS_EN adds BranchCnt/TakenCnt counters.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ValidD..RD2D          decode-stage instruction fields (operands already forwarded)
//   StallE                hold the ID/EX register
//   PCsrcE, FlushD        redirect fetch / squash the fetch-decode register
//   PCTargetE             redirect target, 0 when not redirecting
//   ValidE                E slot holds a real instruction
//   PCPlus4E              link value for JAL/JALR writeback
//   BranchCnt, TakenCnt   (BRANCH_STATS_EN only) resolved control-flow / taken counts

module branch_resolve #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidD,
    input  logic                  BranchD,
    input  logic                  JumpD,
    input  logic                  JalrD,
    input  logic [2:0]            Funct3D,
    input  logic [DATA_WIDTH-1:0] PCd,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic                  StallE,
    output logic                  PCsrcE,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  FlushD,
    output logic                  ValidE,
    output logic [DATA_WIDTH-1:0] PCPlus4E
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]           BranchCnt,
    output logic [31:0]           TakenCnt
`endif
);

    logic                  r_valid;
    logic                  r_branch;
    logic                  r_jump;
    logic                  r_jalr;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pcplus4;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [DATA_WIDTH-1:0] r_rd1;
    logic [DATA_WIDTH-1:0] r_rd2;

    logic                  w_cond;
    logic                  w_taken;
    logic [DATA_WIDTH-1:0] w_pc_rel;
    logic [DATA_WIDTH-1:0] w_jalr_sum;
    logic [DATA_WIDTH-1:0] w_jalr_tgt;

    localparam logic [DATA_WIDTH-1:0] LSB_CLEAR = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    // A taken instruction replaces itself with a bubble on the next edge,
    // which both squashes the wrong-path decode instruction and limits the
    // redirect to a single cycle. Redirect outranks stall for that reason.
    always_ff @(posedge clk) begin
        if (rst || w_taken) begin
            r_valid   <= 1'b0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_jalr    <= 1'b0;
            r_funct3  <= '0;
            r_pc      <= '0;
            r_pcplus4 <= '0;
            r_imm     <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
        end else if (!StallE) begin
            r_valid   <= ValidD;
            r_branch  <= BranchD;
            r_jump    <= JumpD;
            r_jalr    <= JalrD;
            r_funct3  <= Funct3D;
            r_pc      <= PCd;
            r_pcplus4 <= PCPlus4D;
            r_imm     <= ImmExtD;
            r_rd1     <= RD1D;
            r_rd2     <= RD2D;
        end
    end

    // Funct3 encodings 010 and 011 have no branch meaning and never take.
    always_comb begin
        w_cond = 1'b0;
        case (r_funct3)
            3'b000:  w_cond = (r_rd1 == r_rd2);
            3'b001:  w_cond = (r_rd1 != r_rd2);
            3'b100:  w_cond = ($signed(r_rd1) <  $signed(r_rd2));
            3'b101:  w_cond = ($signed(r_rd1) >= $signed(r_rd2));
            3'b110:  w_cond = (r_rd1 <  r_rd2);
            3'b111:  w_cond = (r_rd1 >= r_rd2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken    = r_valid & (r_jump | r_jalr | (r_branch & w_cond));
    assign w_pc_rel   = r_pc + r_imm;
    assign w_jalr_sum = r_rd1 + r_imm;
    assign w_jalr_tgt = w_jalr_sum & LSB_CLEAR;

    // JALR has priority when flags collide; JAL and branch share PC+imm.
    assign PCsrcE    = w_taken;
    assign FlushD    = w_taken;
    assign PCTargetE = !w_taken ? '0 : (r_jalr ? w_jalr_tgt : w_pc_rel);
    assign ValidE    = r_valid;
    assign PCPlus4E  = r_pcplus4;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_taken_cnt;

    // A control-flow instruction is counted on the edge it leaves E:
    // either it is not stalled, or its own redirect forces it out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (r_valid && (r_branch || r_jump || r_jalr) && (!StallE || w_taken))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_taken)
                r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign BranchCnt = r_branch_cnt;
    assign TakenCnt  = r_taken_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve

module tb_branch_resolve;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         ValidD, BranchD, JumpD, JalrD;
    logic [2:0]   Funct3D;
    logic [W-1:0] PCd, PCPlus4D, ImmExtD, RD1D, RD2D;
    logic         StallE;
    logic         PCsrcE, FlushD, ValidE;
    logic [W-1:0] PCTargetE, PCPlus4E;
`ifdef BRANCH_STATS_EN
    logic [31:0]  BranchCnt, TakenCnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .ValidD(ValidD), .BranchD(BranchD), .JumpD(JumpD), .JalrD(JalrD),
        .Funct3D(Funct3D), .PCd(PCd), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
        .RD1D(RD1D), .RD2D(RD2D), .StallE(StallE),
        .PCsrcE(PCsrcE), .PCTargetE(PCTargetE), .FlushD(FlushD),
        .ValidE(ValidE), .PCPlus4E(PCPlus4E)
`ifdef BRANCH_STATS_EN
        , .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the instruction occupying E.
    typedef struct {
        bit           valid, branch, jump, jalr;
        bit [2:0]     f3;
        bit [W-1:0]   pc, pc4, imm, rd1, rd2;
    } slot_t;

    slot_t  m;
    longint m_bcnt, m_tcnt;

    function automatic bit cond_of(slot_t s);
        case (s.f3)
            3'd0: return s.rd1 == s.rd2;
            3'd1: return s.rd1 != s.rd2;
            3'd4: return $signed(s.rd1) <  $signed(s.rd2);
            3'd5: return $signed(s.rd1) >= $signed(s.rd2);
            3'd6: return s.rd1 <  s.rd2;
            3'd7: return s.rd1 >= s.rd2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit taken_of(slot_t s);
        return s.valid && (s.jump || s.jalr || (s.branch && cond_of(s)));
    endfunction

    function automatic bit [W-1:0] target_of(slot_t s);
        bit [W-1:0] sum;
        if (!taken_of(s)) return '0;
        if (s.jalr) begin
            sum = s.rd1 + s.imm;
            sum[0] = 1'b0;
            return sum;
        end
        return s.pc + s.imm;
    endfunction

    // Advance the model and the DUT by one clock edge, then settle.
    task automatic tick();
        slot_t nx;
        bit    tk;
        tk = taken_of(m);
        nx = m;
        if (rst) begin
            nx = '{default: '0};
            m_bcnt = 0;
            m_tcnt = 0;
        end else begin
            if (m.valid && (m.branch || m.jump || m.jalr) && (!StallE || tk)) m_bcnt++;
            if (tk) m_tcnt++;
            if (tk) nx = '{default: '0};
            else if (!StallE) begin
                nx.valid = ValidD;   nx.branch = BranchD; nx.jump = JumpD;
                nx.jalr  = JalrD;    nx.f3 = Funct3D;     nx.pc = PCd;
                nx.pc4   = PCPlus4D; nx.imm = ImmExtD;    nx.rd1 = RD1D;
                nx.rd2   = RD2D;
            end
        end
        @(posedge clk);
        m = nx;
        #1;
    endtask

    task automatic idle_inputs();
        ValidD = 0; BranchD = 0; JumpD = 0; JalrD = 0; Funct3D = 0;
        PCd = 0; PCPlus4D = 0; ImmExtD = 0; RD1D = 0; RD2D = 0; StallE = 0;
    endtask

    task automatic branch_in(input bit [2:0] f3, input bit [W-1:0] pc,
                             input bit [W-1:0] imm, input bit [W-1:0] a, input bit [W-1:0] b);
        idle_inputs();
        ValidD = 1; BranchD = 1; Funct3D = f3; PCd = pc; PCPlus4D = pc + 4;
        ImmExtD = imm; RD1D = a; RD2D = b;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            ValidD = 1; BranchD = $urandom; JumpD = $urandom; JalrD = $urandom;
            Funct3D = $urandom; PCd = $urandom; PCPlus4D = $urandom; ImmExtD = $urandom;
            RD1D = $urandom; RD2D = $urandom; StallE = $urandom;
            tick();
            checks++;
            if ({PCsrcE, FlushD, ValidE, PCTargetE, PCPlus4E} !== '0) begin
                errors++;
                $display("FAIL reset cyc%0d: PCsrcE=%b FlushD=%b ValidE=%b tgt=%h pc4=%h, want all 0",
                         i, PCsrcE, FlushD, ValidE, PCTargetE, PCPlus4E);
            end
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_beq();
        branch_in(3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        tick();
        idle_inputs();
        checks++;
        if (PCsrcE !== 1'b1 || FlushD !== 1'b1 || PCTargetE !== 32'h120) begin
            errors++;
            $display("FAIL beq_taken: PCsrcE=%b FlushD=%b tgt=%h, want 1 1 00000120",
                     PCsrcE, FlushD, PCTargetE);
        end
        tick();
        checks++;
        if (ValidE !== 1'b0 || PCsrcE !== 1'b0) begin
            errors++;
            $display("FAIL beq_bubble: ValidE=%b PCsrcE=%b, want 0 0", ValidE, PCsrcE);
        end
    endtask

    task automatic test_signed_unsigned();
        branch_in(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        idle_inputs();
        checks++;
        if (PCsrcE !== 1'b1 || PCTargetE !== 32'h240) begin
            errors++;
            $display("FAIL blt_signed: PCsrcE=%b tgt=%h, want 1 00000240", PCsrcE, PCTargetE);
        end
        tick();
        branch_in(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1);
        tick();
        idle_inputs();
        checks++;
        if (PCsrcE !== 1'b0 || PCTargetE !== 32'h0 || ValidE !== 1'b1) begin
            errors++;
            $display("FAIL bltu_unsigned: PCsrcE=%b tgt=%h ValidE=%b, want 0 00000000 1",
                     PCsrcE, PCTargetE, ValidE);
        end
        tick();
    endtask

    task automatic test_jalr();
        idle_inputs();
        ValidD = 1; JalrD = 1; PCd = 32'h4C; PCPlus4D = 32'h50; RD1D = 32'h1003; ImmExtD = 32'h4;
        tick();
        idle_inputs();
        checks++;
        if (PCsrcE !== 1'b1 || PCTargetE !== 32'h1006 || PCPlus4E !== 32'h50) begin
            errors++;
            $display("FAIL jalr: PCsrcE=%b tgt=%h pc4=%h, want 1 00001006 00000050",
                     PCsrcE, PCTargetE, PCPlus4E);
        end
        tick();
    endtask

    task automatic test_stall();
        branch_in(3'b001, 32'h300, 32'h10, 32'd7, 32'd7);
        tick();
        for (int i = 0; i < 3; i++) begin
            branch_in(3'b000, 32'h900 + i, 32'h8, 32'd1, 32'd1);
            StallE = 1;
            tick();
            checks++;
            if (ValidE !== 1'b1 || PCPlus4E !== 32'h304 || PCsrcE !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: ValidE=%b pc4=%h PCsrcE=%b, want 1 00000304 0",
                         i, ValidE, PCPlus4E, PCsrcE);
            end
        end
        idle_inputs();
        ValidD = 1; JumpD = 1; PCd = 32'h400; PCPlus4D = 32'h404; ImmExtD = 32'hFFFF_FFF0;
        tick();
        checks++;
        if (PCsrcE !== 1'b1 || PCTargetE !== 32'h3F0) begin
            errors++;
            $display("FAIL jal_redirect: PCsrcE=%b tgt=%h, want 1 000003f0", PCsrcE, PCTargetE);
        end
        StallE = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (PCsrcE !== 1'b0 || ValidE !== 1'b0 || PCTargetE !== 32'h0) begin
                errors++;
                $display("FAIL jal_stall_bubble%0d: PCsrcE=%b ValidE=%b tgt=%h, want 0 0 0",
                         i, PCsrcE, ValidE, PCTargetE);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 49) == 0);
            ValidD  = ($urandom_range(0, 3) != 0);
            BranchD = ($urandom_range(0, 1) == 0);
            JumpD   = ($urandom_range(0, 5) == 0);
            JalrD   = ($urandom_range(0, 5) == 0);
            Funct3D = $urandom;
            PCd     = $urandom;
            PCPlus4D = PCd + 4;
            ImmExtD = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            RD1D    = $urandom;
            RD2D    = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
            StallE  = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (PCsrcE !== taken_of(m) || FlushD !== taken_of(m) || PCTargetE !== target_of(m) ||
                ValidE !== m.valid || PCPlus4E !== m.pc4) begin
                errors++;
                $display("FAIL random%0d: got src=%b fl=%b tgt=%h v=%b pc4=%h want src=%b tgt=%h v=%b pc4=%h",
                         i, PCsrcE, FlushD, PCTargetE, ValidE, PCPlus4E,
                         taken_of(m), target_of(m), m.valid, m.pc4);
            end
`ifdef BRANCH_STATS_EN
            checks++;
            if (BranchCnt !== m_bcnt[31:0] || TakenCnt !== m_tcnt[31:0]) begin
                errors++;
                $display("FAIL random_stats%0d: got %0d/%0d want %0d/%0d",
                         i, BranchCnt, TakenCnt, m_bcnt, m_tcnt);
            end
`endif
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        branch_in(3'b000, 32'h10, 32'h8, 32'd3, 32'd3);   tick();  // taken
        idle_inputs();                                     tick();
        branch_in(3'b001, 32'h20, 32'h8, 32'd3, 32'd3);   tick();  // not taken
        branch_in(3'b110, 32'h24, 32'h8, 32'd1, 32'd2);   tick();  // taken
        idle_inputs();                                     tick();
        ValidD = 1; JumpD = 1; PCd = 32'h30; ImmExtD = 32'h40; tick();
        idle_inputs();                                     tick();
        checks++;
        if (BranchCnt !== 32'd4 || TakenCnt !== 32'd3) begin
            errors++;
            $display("FAIL stats: BranchCnt=%0d TakenCnt=%0d, want 4 3", BranchCnt, TakenCnt);
        end
    endtask
`endif

    initial begin
        m = '{default: '0};
        m_bcnt = 0;
        m_tcnt = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jalr();
        test_stall();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
